// File: rtl/onehot_scan_dec.sv
// Registered one-hot decoder with a valid/ready direct-decode mode and an
// auto-scan mode that steps through unmasked channels at a programmable rate.
module onehot_scan_dec #(
    parameter  int SEL_W = 3,
    parameter  int DIV_W = 16,
    localparam int N     = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     mask,
    input  logic [DIV_W-1:0] div,
    output logic [N-1:0]     y,
    output logic [SEL_W-1:0] idx,
    output logic             tick
);

    logic [DIV_W-1:0] pc, pc_d;
    logic [N-1:0]     y_d;
    logic [SEL_W-1:0] idx_d, nxt;
    logic             tick_d;
    logic             accept;

    assign in_ready = en & ~mode & ~rst;
    assign accept   = in_valid & in_ready;

    // Search downwards so the nearest unmasked channel after idx is the last
    // one written; falls back to idx when no other channel is enabled.
    always_comb begin
        logic [SEL_W-1:0] j;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        nxt = idx;
        j   = '0;
        for (int k = N - 1; k >= 1; k--) begin
            j = idx + SEL_W'(k);
            if (mask[j]) nxt = j;
        end
    end

    // Direct mode and en = 0 both hold the prescaler at zero, so any mode
    // change restarts the dwell from a cleared count.
    always_comb begin
        y_d    = y;
        idx_d  = idx;
        tick_d = 1'b0;
        pc_d   = '0;
        if (!en) begin
            y_d = '0;
        end else if (!mode) begin
            if (accept) begin
                idx_d = sel_in;
                y_d   = N'(1) << sel_in;
            end
        end else begin
            if (pc == div) begin
                idx_d  = nxt;
                tick_d = 1'b1;
            end else begin
                pc_d = pc + DIV_W'(1);
            end
            y_d = (N'(1) << idx_d) & mask;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            y    <= '0;
            idx  <= '0;
            tick <= 1'b0;
            pc   <= '0;
        end else begin
            y    <= y_d;
            idx  <= idx_d;
            tick <= tick_d;
            pc   <= pc_d;
        end
    end

endmodule

// File: tb/tb_onehot_scan_dec.sv
// Self-checking bench for onehot_scan_dec: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_onehot_scan_dec;

    localparam int SEL_W = 3;
    localparam int DIV_W = 16;
    localparam int N     = 1 << SEL_W;

    logic             clk = 1'b0;
    logic             rst, en, mode, in_valid, in_ready, tick;
    logic [SEL_W-1:0] sel_in, idx;
    logic [N-1:0]     mask, y;
    logic [DIV_W-1:0] div;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [N-1:0]     m_y;
    logic [SEL_W-1:0] m_idx;
    logic             m_tick;
    int               m_pc;

    onehot_scan_dec #(.SEL_W(SEL_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
        .in_valid(in_valid), .in_ready(in_ready), .mask(mask), .div(div),
        .y(y), .idx(idx), .tick(tick)
    );

    always #5 clk = ~clk;

    function automatic int next_unmasked(input int cur, input logic [N-1:0] m);
        for (int k = 1; k < N; k++)
            if (m[(cur + k) % N]) return (cur + k) % N;
        return cur;
    endfunction

    // One clock of the model from the rules, using the pre-edge inputs.
    task automatic model_step();
        int ni;
        if (rst) begin
            m_y = '0; m_idx = '0; m_tick = 1'b0; m_pc = 0;
        end else if (!en) begin
            m_y = '0; m_tick = 1'b0; m_pc = 0;
        end else if (!mode) begin
            m_tick = 1'b0; m_pc = 0;
            if (in_valid) begin
                m_idx = sel_in;
                m_y   = N'(2 ** int'(sel_in));
            end
        end else begin
            if (m_pc == int'(div)) begin
                m_pc   = 0;
                m_tick = 1'b1;
                ni     = next_unmasked(int'(m_idx), mask);
                m_idx  = SEL_W'(ni);
            end else begin
                m_pc   = m_pc + 1;
                m_tick = 1'b0;
            end
            m_y = mask[m_idx] ? N'(2 ** int'(m_idx)) : '0;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int s);
        en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel_in = SEL_W'(s);
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; sel_in = 3'd3;
        mask = '1; div = '0;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b want=0", in_ready);
        end
        cycle(); cycle();
        total++;
        if ({y, idx, tick} !== {8'h00, 3'd0, 1'b0}) begin
            bad++; $display("FAIL reset_state got y=%h idx=%0d tick=%b want 00/0/0", y, idx, tick);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_direct();
        logic [N-1:0] exp;
        rst = 1'b0; en = 1'b1; mode = 1'b0;
        for (int s = 0; s < N; s++) begin
            in_valid = 1'b1; sel_in = SEL_W'(s);
            #1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++; $display("FAIL direct_ready s=%0d got=%b want=1", s, in_ready);
            end
            cycle();
            exp = '0; exp[s] = 1'b1;
            total++;
            if (y !== exp || idx !== SEL_W'(s) || tick !== 1'b0) begin
                bad++; $display("FAIL direct_dec s=%0d got y=%h idx=%0d want y=%h", s, y, idx, exp);
            end
        end
        in_valid = 1'b0; sel_in = 3'd2;
        cycle();
        total++;
        if (y !== 8'h80 || idx !== 3'd7) begin
            bad++; $display("FAIL direct_hold got y=%h idx=%0d want 80/7", y, idx);
        end
        en = 1'b0; in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL disable_ready got=%b want=0", in_ready);
        end
        cycle();
        total++;
        if (y !== 8'h00 || idx !== 3'd7) begin
            bad++; $display("FAIL disable_y got y=%h idx=%0d want 00/7", y, idx);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_scan_full();
        int since = 0;
        int n_tick = 0;
        load(0);
        mode = 1'b1; mask = 8'hFF; div = 16'd3;
        for (int c = 0; c < 36; c++) begin
            cycle();
            since++;
            total++;
            if ({y, idx, tick} !== {m_y, m_idx, m_tick}) begin
                bad++; $display("FAIL scan_full c=%0d got %h/%0d/%b want %h/%0d/%b", c, y, idx, tick, m_y, m_idx, m_tick);
            end
            if (tick === 1'b1) begin
                n_tick++;
                total++;
                if (since != 4 || idx !== SEL_W'(n_tick % N) || y !== N'(2 ** (n_tick % N))) begin
                    bad++; $display("FAIL scan_step n=%0d got gap=%0d idx=%0d y=%h want gap=4 idx=%0d", n_tick, since, idx, y, n_tick % N);
                end
                since = 0;
            end
        end
        total++;
        if (n_tick != 9) begin
            bad++; $display("FAIL scan_ticks got=%0d want=9", n_tick);
        end
    endtask

    task automatic test_sparse();
        logic [SEL_W-1:0] exp_i [3] = '{3'd3, 3'd7, 3'd0};
        logic [N-1:0]     exp_y [3] = '{8'h08, 8'h80, 8'h01};
        load(0);
        mode = 1'b1; mask = 8'h89; div = 16'd0;
        for (int c = 0; c < 9; c++) begin
            cycle();
            total++;
            if (idx !== exp_i[c % 3] || y !== exp_y[c % 3] || tick !== 1'b1) begin
                bad++; $display("FAIL sparse c=%0d got %h/%0d/%b want %h/%0d/1", c, y, idx, tick, exp_y[c % 3], exp_i[c % 3]);
            end
        end
    endtask

    task automatic test_mask_edge();
        load(2);
        mode = 1'b1; mask = 8'h00; div = 16'd2;
        for (int c = 1; c <= 9; c++) begin
            cycle();
            total++;
            if (y !== 8'h00 || idx !== 3'd2 || tick !== (c % 3 == 0)) begin
                bad++; $display("FAIL mask_zero c=%0d got %h/%0d/%b want 00/2/%0d", c, y, idx, tick, c % 3 == 0);
            end
        end
        load(0);
        mode = 1'b1; mask = 8'h10;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            total++;
            if ({y, idx, tick} !== {m_y, m_idx, m_tick} || (c >= 3 && (idx !== 3'd4 || y !== 8'h10))) begin
                bad++; $display("FAIL mask_single c=%0d got %h/%0d/%b want %h/%0d/%b", c, y, idx, tick, m_y, m_idx, m_tick);
            end
        end
    endtask

    task automatic test_rst_mid();
        int guard = 0;
        load(0);
        mode = 1'b1; mask = 8'hFF; div = 16'd1;
        while (idx !== 3'd5 && guard < 50) begin
            cycle();
            guard++;
        end
        total++;
        if (idx !== 3'd5) begin
            bad++; $display("FAIL rst_mid_reach got idx=%0d want=5", idx);
        end
        cycle();
        rst = 1'b1;
        cycle();
        total++;
        if ({y, idx, tick} !== {8'h00, 3'd0, 1'b0}) begin
            bad++; $display("FAIL rst_mid got %h/%0d/%b want 00/0/0", y, idx, tick);
        end
        rst = 1'b0;
        cycle();
        total++;
        if ({y, idx, tick} !== {8'h01, 3'd0, 1'b0}) begin
            bad++; $display("FAIL rst_dwell1 got %h/%0d/%b want 01/0/0", y, idx, tick);
        end
        cycle();
        total++;
        if ({y, idx, tick} !== {8'h02, 3'd1, 1'b1}) begin
            bad++; $display("FAIL rst_dwell2 got %h/%0d/%b want 02/1/1", y, idx, tick);
        end
    endtask

    task automatic test_mode_switch();
        load(0);
        mode = 1'b1; mask = 8'hFF; div = 16'd3;
        for (int c = 0; c < 6; c++) cycle();
        mode = 1'b0;
        cycle();
        total++;
        if ({y, idx, tick} !== {8'h02, 3'd1, 1'b0}) begin
            bad++; $display("FAIL switch_hold got %h/%0d/%b want 02/1/0", y, idx, tick);
        end
        in_valid = 1'b1; sel_in = 3'd6;
        cycle();
        total++;
        if (y !== 8'h40 || idx !== 3'd6) begin
            bad++; $display("FAIL switch_accept got y=%h idx=%0d want 40/6", y, idx);
        end
        in_valid = 1'b0; mode = 1'b1; mask = 8'h27;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            total++;
            if ((c < 4 && (idx !== 3'd6 || tick !== 1'b0)) ||
                (c == 4 && (idx !== 3'd0 || y !== 8'h01 || tick !== 1'b1))) begin
                bad++; $display("FAIL switch_back c=%0d got %h/%0d/%b", c, y, idx, tick);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 31) == 0);
            en       = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid = $urandom_range(0, 1);
            sel_in   = SEL_W'($urandom);
            if ($urandom_range(0, 7) == 0) mask = N'($urandom);
            if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 3));
            #1;
            total++;
            if (in_ready !== (en & ~mode & ~rst)) begin
                bad++; $display("FAIL rand_ready c=%0d got=%b", c, in_ready);
            end
            cycle();
            total++;
            if ({y, idx, tick} !== {m_y, m_idx, m_tick}) begin
                bad++; $display("FAIL rand c=%0d got %h/%0d/%b want %h/%0d/%b", c, y, idx, tick, m_y, m_idx, m_tick);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
        sel_in = '0; mask = '0; div = '0;
        m_y = '0; m_idx = '0; m_tick = 1'b0; m_pc = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_direct();
        test_scan_full();
        test_sparse();
        test_mask_edge();
        test_rst_mid();
        test_mode_switch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/onehot_scan_dec.md
# onehot_scan_dec

Parametrised, registered one-hot decoder with enable and an auto-scan mode, driving 2^SEL_W select lines such as LED or digit enables. In direct mode it decodes an index accepted over a valid/ready handshake. In scan mode it steps through the unmasked channels at a programmable rate. It sits between the core-side index source and board-level multiplexed displays, and supersedes fixed-width combinational decoders.

## Interface
- SEL_W, 3: index width; N = 2^SEL_W outputs
- DIV_W, 16: scan prescaler width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; 0 forces y to zero
- mode  in  1  0 = direct decode, 1 = auto-scan
- sel_in  in  SEL_W  index to decode (direct mode)
- in_valid  in  1  sel_in valid
- in_ready  out  1  = en & ~mode & ~rst (combinational)
- mask  in  N  scan channel enable, bit i enables channel i
- div  in  DIV_W  scan dwell = div+1 cycles per channel
- y  out  N  registered one-hot select (or all zero)
- idx  out  SEL_W  registered current channel index
- tick  out  1  one-cycle pulse when scan advances idx

## Operation
- Reset values:
  - y = 0, idx = 0, tick = 0, prescaler pc = 0.
  - in_ready = 0 while rst = 1.
- en = 0 (any mode):
  - Next cycle y = 0, pc = 0, tick = 0.
  - idx holds; handshake disabled.
- Direct mode (en = 1, mode = 0):
  - Accept when in_valid & in_ready.
  - On accept: next cycle idx = sel_in, y = 1 << sel_in.
  - Without accept: y and idx hold.
  - pc held at 0; tick = 0; mask ignored.
- Scan mode (en = 1, mode = 1):
  - pc counts 0..div. When pc == div, the next cycle has pc = 0, idx = nxt and tick = 1; otherwise pc increments and tick = 0.
  - nxt is the first index j in idx+1, idx+2, … (mod N, wrapping N-1 -> 0) with mask[j] = 1, searched over the N-1 other channels.
  - If no other channel is unmasked, nxt = idx; tick still pulses.
  - y = (1 << idx) & mask, registered and updated every cycle, so a masked current channel shows y = 0.
  - mask = 0: y = 0, idx holds, tick still pulses every div+1 cycles.
  - div = 0: advance every cycle, tick held high continuously.
- Mode switch:
  - Any change of mode clears pc in the next cycle.
  - Entering scan: idx is kept and the first advance comes div+1 cycles later.
  - Entering direct: y and idx keep their last scan values until the first accept.
- Simultaneous events:
  - rst dominates en and mode.
  - en = 0 dominates mode and the handshake.
  - Changes to mask or div take effect on the next evaluation; no glitch handling is required.
- Reset asserted mid-scan or mid-handshake: all state returns to reset values in the next cycle. Any pending accept is dropped.

## Timing
- Direct latency: accept at edge k -> y and idx valid after edge k, i.e. 1 cycle.
- Scan period: exactly div+1 cycles between tick pulses. tick is coincident with the cycle idx takes its new value.
- y is a pure register output with no combinational path from inputs. in_ready is combinational from en, mode and rst.
- Throughput: one accept per cycle in direct mode.

## Test plan
- Reset, then en = 1, mode = 0, valid sel_in = 0..7 on consecutive cycles -> y = 0x01, 0x02, … 0x80 one cycle after each, in_ready = 1 throughout. With en = 0 -> y = 0x00 next cycle, in_ready = 0.
- Scan, SEL_W = 3, mask = 0xFF, div = 3 -> idx 0, 1, 2 … 7, 0 with 4-cycle dwell, tick every 4th cycle, y = 0x01, 0x02, …, wraps to 0x01.
- Scan, mask = 0x89, div = 0 -> idx sequence 0, 3, 7, 0, 3, … one step per cycle, y = 0x01, 0x08, 0x80; tick constantly 1.
- Scan with mask = 0x00 -> y = 0, idx frozen, tick every div+1 cycles. Scan with mask = 0x10 starting at idx = 0 -> after first tick idx = 4 and stays, y = 0x10.
- Mid-scan rst pulse at idx = 5 -> next cycle y = 0, idx = 0, tick = 0, pc = 0. Scan then restarts with a full div+1 dwell.
- Switch mode 1 -> 0 during dwell -> y/idx hold, pc = 0. Valid sel_in = 6 -> y = 0x40 next cycle. Switch back -> first tick after div+1 cycles, advancing to the next unmasked index after 6.
